// File: rtl/io_rx_conditioner.sv
// rtl/io_rx_conditioner.sv - per-channel synchroniser, debounce filter and edge pulses for pad receive bits
// Optional feature macro: IO_RX_CONDITIONER_GLITCHCOUNT_EN (adds per-channel saturating glitch counters)
module io_rx_conditioner #(
  parameter int   RXCOUNT         = 2,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [RXCOUNT-1:0] func_receive,
  output logic [RXCOUNT-1:0] level,
  output logic [RXCOUNT-1:0] rise,
  output logic [RXCOUNT-1:0] fall,
`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
  output logic [8*RXCOUNT-1:0] glitch_count,
`endif
  output logic               changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (RXCOUNT < 1) begin : g_err_rxcount
      $error("io_rx_conditioner: RXCOUNT must be > 0");
    end
    if (SYNC_STAGES < 2) begin : g_err_sync
      $error("io_rx_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_err_debounce
      $error("io_rx_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  logic [RXCOUNT-1:0] sync_q [SYNC_STAGES];
  logic [RXCOUNT-1:0] s;
  logic [CW-1:0]      cnt_q  [RXCOUNT];
  logic [CW-1:0]      cnt_d  [RXCOUNT];
  logic [RXCOUNT-1:0] accept;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; keeps running even while the filters are frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {RXCOUNT{INIT_LEVEL}};
    end else begin
      sync_q[0] <= func_receive;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Debounce decision per channel: abort on agreement, accept on the last differing cycle, else count
  always_comb begin
    for (int ch = 0; ch < RXCOUNT; ch++) begin
      cnt_d[ch]  = '0;
      accept[ch] = 1'b0;
      if (enable && (s[ch] != level[ch])) begin
        if (cnt_q[ch] == LAST) accept[ch] = 1'b1;
        else                   cnt_d[ch]  = cnt_q[ch] + 1'b1;
      end
    end
  end

  // Counters, accepted level and registered edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < RXCOUNT; ch++) cnt_q[ch] <= '0;
      level   <= {RXCOUNT{INIT_LEVEL}};
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      for (int ch = 0; ch < RXCOUNT; ch++) cnt_q[ch] <= cnt_d[ch];
      // accept implies s differs from level, so flipping level loads s
      level   <= level ^ accept;
      rise    <= accept & s;
      fall    <= accept & ~s;
      changed <= |accept;
    end
  end

`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
  logic [7:0]         gcnt_q [RXCOUNT];
  logic [RXCOUNT-1:0] glitch;

  // A glitch is a pending debounce that aborts because the input went back to level
  always_comb begin
    for (int ch = 0; ch < RXCOUNT; ch++) begin
      glitch[ch] = enable && (s[ch] == level[ch]) && (cnt_q[ch] != '0);
    end
  end

  // Saturating glitch counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < RXCOUNT; ch++) gcnt_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < RXCOUNT; ch++) begin
        if (glitch[ch] && (gcnt_q[ch] != 8'hFF)) gcnt_q[ch] <= gcnt_q[ch] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < RXCOUNT; g++) begin : g_gc_flat
    assign glitch_count[8*g +: 8] = gcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_io_rx_conditioner.sv
// tb/tb_io_rx_conditioner.sv - self-checking bench for io_rx_conditioner with a run-length reference model
module tb_io_rx_conditioner;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [NCH-1:0] func_receive;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           changed;
`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
  logic [8*NCH-1:0] glitch_count;
`endif

  int errors = 0;
  int checks = 0;

  io_rx_conditioner #(
    .RXCOUNT(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .func_receive(func_receive),
    .level(level), .rise(rise), .fall(fall),
`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
    .glitch_count(glitch_count),
`endif
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: input delay line as a queue, plus per-channel run length of disagreement
  logic [NCH-1:0] pipe [$];
  logic [NCH-1:0] m_level, m_rise, m_fall;
  logic           m_changed;
  int             m_run [NCH];
  int             m_gc  [NCH];

  task automatic model_reset();
    pipe.delete();
    repeat (SYNC) pipe.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    for (int c = 0; c < NCH; c++) begin m_run[c] = 0; m_gc[c] = 0; end
  endtask

  task automatic model_step(input logic [NCH-1:0] rx, input logic en, input logic r);
    logic [NCH-1:0] seen;
    if (r) begin
      model_reset();
    end else begin
      seen = pipe.pop_front();
      pipe.push_back(rx);
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < NCH; c++) begin
        if (!en) begin
          m_run[c] = 0;
        end else if (seen[c] == m_level[c]) begin
          if (m_run[c] > 0 && m_gc[c] < 255) m_gc[c]++;
          m_run[c] = 0;
        end else if (m_run[c] + 1 == DEB) begin
          m_level[c] = seen[c];
          if (seen[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
          m_run[c] = 0;
        end else begin
          m_run[c]++;
        end
      end
      m_changed = |(m_rise | m_fall);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [NCH-1:0] rx, input logic en, input logic r);
    func_receive = rx; enable = en; rst = r;
    @(posedge clk);
    model_step(rx, en, r);
    #1;
    check("level",   32'(level),   32'(m_level));
    check("rise",    32'(rise),    32'(m_rise));
    check("fall",    32'(fall),    32'(m_fall));
    check("changed", 32'(changed), 32'(m_changed));
`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
    for (int c = 0; c < NCH; c++) check("glitch_count", 32'(glitch_count[8*c +: 8]), 32'(m_gc[c]));
`endif
  endtask

  // Ticks until level[ch] reaches val or the bound expires; returns the tick count
  task automatic wait_level(input int ch, input logic val, input logic [NCH-1:0] rx,
                            input int bound, output int n);
    n = 0;
    do begin
      tick(rx, 1'b1, 1'b0);
      n++;
    end while (level[ch] !== val && n < bound);
  endtask

  initial begin
    int n, nchg, gc_before;
    logic seen_bad;
    logic [NCH-1:0] rx;
    int hold [NCH];

    model_reset();
    func_receive = '0; enable = 1'b1; rst = 1'b1;

    // Reset and quiet idle
    repeat (3) tick(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(2'b00, 1'b1, 1'b0);
      check("idle_level", 32'(level), 32'd0);
      check("idle_pulses", 32'({rise, fall, changed}), 32'd0);
    end

    // Ch0 clean step: 18-cycle latency with single rise pulse
    wait_level(0, 1'b1, 2'b01, 40, n);
    check("ch0_latency", 32'(n), 32'd18);
    check("ch0_rise", 32'(rise), 32'b01);
    check("ch0_changed", 32'(changed), 32'd1);
    tick(2'b01, 1'b1, 1'b0);
    check("ch0_rise_clear", 32'(rise), 32'd0);
    repeat (25) tick(2'b00, 1'b1, 1'b0);
    check("ch0_back_low", 32'(level), 32'd0);

    // Ch1 10-cycle pulse is rejected as a glitch
    gc_before = m_gc[1];
    seen_bad = 1'b0;
    repeat (10) begin tick(2'b10, 1'b1, 1'b0); if (level[1] || rise[1] || fall[1]) seen_bad = 1'b1; end
    repeat (20) begin tick(2'b00, 1'b1, 1'b0); if (level[1] || rise[1] || fall[1]) seen_bad = 1'b1; end
    check("ch1_glitch_rejected", 32'(seen_bad), 32'd0);
    check("ch1_glitch_model", 32'(m_gc[1]), 32'(gc_before + 1));
`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
    check("ch1_glitch_count", 32'(glitch_count[15:8]), 32'(gc_before + 1));
`endif

    // Both channels step together
    wait_level(0, 1'b1, 2'b11, 40, n);
    check("both_latency", 32'(n), 32'd18);
    check("both_rise", 32'(rise), 32'b11);
    nchg = int'(changed);
    repeat (30) begin tick(2'b11, 1'b1, 1'b0); nchg += int'(changed); end
    check("both_changed_once", 32'(nchg), 32'd1);
    repeat (25) tick(2'b00, 1'b1, 1'b0);

    // Enable low freezes the filter; restart from zero once enabled
    seen_bad = 1'b0;
    repeat (40) begin tick(2'b01, 1'b0, 1'b0); if (level[0] || rise[0]) seen_bad = 1'b1; end
    check("frozen_level", 32'(seen_bad), 32'd0);
    wait_level(0, 1'b1, 2'b01, 40, n);
    check("enable_latency", 32'(n), 32'd16);
    check("enable_rise", 32'(rise), 32'b01);
    repeat (25) tick(2'b00, 1'b1, 1'b0);

    // Reset mid-pending discards the count
    repeat (12) tick(2'b01, 1'b1, 1'b0);
    check("pending_level", 32'(level), 32'd0);
    repeat (2) begin
      tick(2'b01, 1'b1, 1'b1);
      check("reset_no_pulse", 32'({rise, fall, changed}), 32'd0);
    end
    wait_level(0, 1'b1, 2'b01, 40, n);
    check("post_reset_latency", 32'(n), 32'd18);
    check("post_reset_rise", 32'(rise), 32'b01);

    // 300 glitches on ch1 saturate its counter
    for (int i = 0; i < 600; i++) begin
      rx = {1'(i % 2 == 0), 1'b1};
      tick(rx, 1'b1, 1'b0);
    end
    check("sat_model", 32'(m_gc[1]), 32'd255);
`ifdef IO_RX_CONDITIONER_GLITCHCOUNT_EN
    check("sat_count", 32'(glitch_count[15:8]), 32'd255);
`endif

    // Randomised hold lengths, enable drops and occasional resets
    rx = '0;
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          rx[c] = ~rx[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 30);
        end
        hold[c]--;
      end
      tick(rx, $urandom_range(0, 15) != 0, $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
